// File: rtl/conv3x3_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : conv3x3_mac_engine
// Description : Sequences a 3x3 window against a per-filter weight ROM and
//               streams one signed accumulated result per filter.
// Revision    : 1.0 - initial release
// ============================================================================
module conv3x3_mac_engine #(
  parameter int NUM_FILTERS = 8,
  parameter int ACC_W       = 20,
  parameter int RELU        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [71:0]      in_window,
  output logic [6:0]       weight_addr,
  input  logic [7:0]       weight_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [2:0]       out_filter,
  output logic             out_last
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [2:0] LAST_FILT = 3'(NUM_FILTERS - 1);

  generate
    if (ACC_W < 18) begin : g_acc_w_check
      $error("ACC_W must be at least 18");
    end
  endgenerate

  state_t                  state;
  logic [2:0]              filt;
  logic [3:0]              k;
  logic                    tap_v;
  logic [3:0]              tap_k;
  logic [71:0]             window;
  logic signed [ACC_W-1:0] acc;

  logic [7:0]              pix;
  logic signed [16:0]      prod;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0]        result;

  // Pixels are unsigned, so a zero MSB makes the 9x8 signed multiply exact.
  always_comb begin
    pix      = window[{tap_k, 3'b000} +: 8];
    prod     = $signed({1'b0, pix}) * $signed(weight_in);
    acc_base = (tap_k == 4'd0) ? '0 : acc;
    acc_next = acc_base + {{(ACC_W-17){prod[16]}}, prod};
    result   = ((RELU != 0) && acc_next[ACC_W-1]) ? '0 : acc_next;
  end

  always_comb begin
    weight_addr = '0;
    if (state == S_MAC) begin
      weight_addr = ({4'b0000, filt} * 7'd9) + {3'b000, k};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      filt       <= '0;
      k          <= '0;
      tap_v      <= 1'b0;
      tap_k      <= '0;
      acc        <= '0;
      window     <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_filter <= '0;
      out_last   <= 1'b0;
    end else begin
      tap_v <= 1'b0;
      if (tap_v) begin
        acc <= acc_next;
      end
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            window   <= in_window;
            filt     <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            state    <= S_MAC;
          end
        end
        S_MAC: begin
          // ROM data for this address returns next cycle, alongside tap_k.
          tap_v <= 1'b1;
          tap_k <= k;
          if (k == 4'd8) begin
            state <= S_DRAIN;
          end else begin
            k <= k + 4'd1;
          end
        end
        S_DRAIN: begin
          out_valid  <= 1'b1;
          out_data   <= result;
          out_filter <= filt;
          out_last   <= (filt == LAST_FILT);
          state      <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              in_ready <= 1'b1;
              state    <= S_IDLE;
            end else begin
              filt  <= filt + 3'd1;
              k     <= '0;
              state <= S_MAC;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv3x3_mac_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv3x3_mac_engine
// Description : Directed, table-driven bench for conv3x3_mac_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv3x3_mac_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [71:0] in_window = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, out_last;
  logic [6:0]  weight_addr;
  logic [7:0]  weight_in;
  logic [19:0] out_data;
  logic [2:0]  out_filter;

  logic        in_ready_r, out_valid_r, out_last_r;
  logic [6:0]  weight_addr_r;
  logic [7:0]  weight_in_r;
  logic [19:0] out_data_r;
  logic [2:0]  out_filter_r;

  logic signed [7:0] rom [72];

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  // Behavioural 1-cycle synchronous ROM, one read port per engine.
  always @(posedge clk) begin
    weight_in   <= rom[weight_addr];
    weight_in_r <= rom[weight_addr_r];
  end

  conv3x3_mac_engine #(.NUM_FILTERS(8), .ACC_W(20), .RELU(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_window(in_window), .weight_addr(weight_addr), .weight_in(weight_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_filter(out_filter), .out_last(out_last)
  );

  conv3x3_mac_engine #(.NUM_FILTERS(8), .ACC_W(20), .RELU(1)) dut_relu (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
    .in_window(in_window), .weight_addr(weight_addr_r), .weight_in(weight_in_r),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
    .out_filter(out_filter_r), .out_last(out_last_r)
  );

  typedef struct {
    string       name;
    logic [71:0] window;
    int          wmode;   // 0: all +1, 1: all -128, 2: filter f -> f-4
    int          exp0;    // result of filter 0
    int          step;    // result increment per filter
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_rom(input int wmode);
    for (int a = 0; a < 72; a++) begin
      case (wmode)
        0:       rom[a] = 8'sd1;
        1:       rom[a] = -8'sd128;
        default: rom[a] = 8'(a / 9 - 4);
      endcase
    end
  endtask

  // Called on a negedge with the engine idle. Steps cycle-by-cycle from the
  // accept edge T, so every address, result and out_valid is checked at its
  // exact nominal cycle (stall cycles at stall_f shift later filters).
  task automatic run_window(input vec_t v, input int stall_f, input int stall_n);
    int exp, expr;
    chk({v.name, " in_ready idle"}, in_ready, 1);
    in_window = v.window;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 9; k++) begin
        chk({v.name, " weight_addr"}, weight_addr, f * 9 + k);
        chk({v.name, " in_ready busy"}, in_ready, 0);
        chk({v.name, " out_valid mac"}, out_valid, 0);
        @(negedge clk);
      end
      chk({v.name, " drain addr"}, weight_addr, 0);
      chk({v.name, " out_valid drain"}, out_valid, 0);
      @(negedge clk);
      exp  = v.exp0 + v.step * f;
      expr = (exp < 0) ? 0 : exp;
      chk({v.name, " out_valid"}, out_valid, 1);
      chk({v.name, " out_data"}, $signed(out_data), exp);
      chk({v.name, " out_filter"}, out_filter, f);
      chk({v.name, " out_last"}, out_last, (f == 7) ? 1 : 0);
      chk({v.name, " relu out_valid"}, out_valid_r, 1);
      chk({v.name, " relu out_data"}, $signed(out_data_r), expr);
      if (f == stall_f) begin
        for (int s = 0; s < stall_n; s++) begin
          out_ready = 1'b0;
          in_valid  = 1'b1;
          in_window = ~v.window;
          @(negedge clk);
          chk({v.name, " stall out_valid"}, out_valid, 1);
          chk({v.name, " stall out_data"}, $signed(out_data), exp);
          chk({v.name, " stall out_filter"}, out_filter, f);
          chk({v.name, " stall out_last"}, out_last, 0);
          chk({v.name, " stall in_ready"}, in_ready, 0);
          chk({v.name, " stall addr"}, weight_addr, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk({v.name, " in_ready after last"}, in_ready, 1);
    chk({v.name, " out_valid after last"}, out_valid, 0);
  endtask

  initial begin
    vecs[0] = '{"ones_w1",   {9{8'd1}},   0, 9,       0};
    vecs[1] = '{"max_w1",    {9{8'd255}}, 0, 2295,    0};
    vecs[2] = '{"max_wneg",  {9{8'd255}}, 1, -293760, 0};
    vecs[3] = '{"ramp_wf",   {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 2, -180, 45};
    vecs[4] = '{"ramp_w1",   {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 0, 45, 0};

    load_rom(0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_filter", out_filter, 0);
    chk("reset out_last", out_last, 0);
    chk("reset weight_addr", weight_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1);

    for (int i = 0; i < 5; i++) begin
      load_rom(vecs[i].wmode);
      run_window(vecs[i], -1, 0);
      @(negedge clk);
    end

    // Backpressure at filter 3 with in_valid pulsed while busy.
    load_rom(2);
    run_window(vecs[3], 3, 5);
    @(negedge clk);

    // Reset in the middle of a window (out_data holds filter 2's result).
    load_rom(0);
    in_window = {9{8'd255}};
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    repeat (39) @(negedge clk);
    chk("pre-reset out_filter", out_filter, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid reset in_ready", in_ready, 1);
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset out_data", out_data, 0);
    chk("mid reset out_filter", out_filter, 0);
    chk("mid reset out_last", out_last, 0);
    chk("mid reset weight_addr", weight_addr, 0);
    @(negedge clk);
    run_window(vecs[0], -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv3x3_mac_engine.md
# conv3x3_mac_engine

Sequencing MAC engine for the first convolution layer. It sits directly downstream of the convolution weight ROM (3x3 kernel, 1 input channel, 8 filters, 72 signed 8-bit weights, 1-cycle synchronous read). It accepts one 3x3 pixel window, drives the ROM address for each filter/tap in turn, and accumulates the nine products per filter. It emits 8 signed filter results, one at a time, over a valid/ready stream.

## Interface
- NUM_FILTERS, 8, filters per window; legal 1..8 (ROM address stays within 0..71).
- ACC_W, 20, accumulator/result width; 20 is the minimum that is overflow-free.
- RELU, 0, 1 clamps negative results to 0 at the output.

Clock, reset and ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  window valid.
- in_ready  out  1  engine can accept a window.
- in_window  in  72  nine unsigned 8-bit pixels; tap k (k=0..8: p00,p01,p02,p10..p22) at bits [8k+7:8k].
- weight_addr  out  7  ROM address = filter*9 + k.
- weight_in  in  8  signed ROM data, valid one cycle after weight_addr.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  ACC_W  signed filter sum.
- out_filter  out  3  filter index of out_data.
- out_last  out  1  high with the final filter (NUM_FILTERS-1).

## Operation
- FSM states: IDLE, MAC, DRAIN, OUT.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_window, set filt=0, k=0, and go to MAC. At all other times in_ready=0, and in_valid is ignored (no queueing).
- MAC: weight_addr = filt*9+k, combinational from the registered filt/k, and 0 in all other states. k increments each cycle. When k=8, go to DRAIN.
- Tap pipeline: registered tap_v/tap_k copy the MAC-cycle k. When tap_v is set: acc <= (tap_k==0 ? 0 : acc) + $signed({1'b0,pix[tap_k]}) * weight_in.
  - The product is 9x8 signed, giving 17 bits, sign-extended to ACC_W.
  - Range: -293760..+291465, so there is no overflow at ACC_W=20.
- DRAIN: one cycle in which tap k=8 accumulates. Then go to OUT.
- OUT: out_valid=1.
  - out_data = acc, or 0 if RELU=1 and acc<0.
  - out_filter = filt; out_last = (filt==NUM_FILTERS-1).
  - On out_ready: if last, go to IDLE; otherwise filt++, k=0, go to MAC.
- Backpressure: while OUT and !out_ready, out_valid, out_data, out_filter and out_last hold stable. No ROM activity, weight_addr=0.
- out_data, out_filter and out_last are registered. The pixel latch is stable from accept until return to IDLE.
- Reset, including mid-window:
  - state becomes IDLE and filt, k, tap_v and acc clear to 0.
  - out_valid=0, out_data=0, out_filter=0, out_last=0, weight_addr=0.
  - in_ready=1 in the first cycle after rst deasserts.
  - Any partial window is discarded and no partial result is emitted.

## Timing
- Window accepted at edge T, so MAC runs over cycles T+1..T+9, DRAIN is T+10, and out_valid for filter 0 is high at T+11.
- Each filter takes 11 cycles with out_ready held at 1. Filter f is valid at T+11+11f, so filter 7 is at T+88.
- in_ready rises at T+89, so the next window can be accepted at edge T+89. Throughput is 1 window per 89 cycles.
- weight_in for the address presented in cycle c is used in cycle c+1. There is no other ROM latency assumption.
- Each cycle of out_ready=0 in OUT adds exactly 1 cycle to all later timing.

## Test plan
- ROM default weights all +1, in_window all pixels = 1 -> 8 results, each out_data=9, out_filter 0..7, out_last only on filter 7, at T+11+11f.
- Pixels all 255, weights +1 -> each out_data=2295. Check the weight_addr sequence 0..71 in order, one per MAC cycle.
- Behavioral ROM with all weights -128, pixels 255:
  - RELU=0 -> out_data = -293760 (0xB8480 in 20 bits).
  - RELU=1 -> 0.
- Pixels k+1 and weights filter f = f-4 (signed) -> out_data = 45*(f-4), i.e. -180,-135,...,135.
- out_ready low for 5 cycles at filter 3 -> out_valid, out_data and out_filter stable; filter 4 arrives 5 cycles later than nominal. in_valid pulsed while busy -> ignored, in_ready stays 0.
- rst asserted at T+40 -> the next cycle shows IDLE, in_ready=1, out_valid=0 and all outputs 0. A new window then yields correct results with no stale accumulation.
